serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor that computes diff = a - b, LSB first, one bit per clock.
- It is the arithmetic inverse of the team's half-adder datapath. Its bit-slice is built from two half-subtractors plus a borrow flip-flop.
- It sits behind a simple start/busy/done handshake, so control logic can trade area for latency on wide operands.

Parameters:
- WIDTH, 8, operand and result width in bits (min 2).
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; never overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset; one clock; all state clears immediately.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; diff/borrow valid.
- diff  output  WIDTH  result (a - b) mod 2^WIDTH; held until the next accepted start.
- borrow  output  1  final borrow out; 1 iff a < b unsigned; held with diff.

Behaviour:
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow=0, internal shift regs=0, counter=0, borrow FF=0.
- Reset is asynchronous and takes effect mid-operation with no completion pulse.
- State machine:
  - IDLE: start=1 at an edge -> latch a into sa and b into sb, clear borrow FF, counter=0, go to RUN. Otherwise stay.
  - RUN: each edge, the bit-slice takes x=sa[0], y=sb[0], bi=borrow FF.
    - Slice equations: d = x^y^bi; bo = (~x&y) | (~(x^y)&bi).
    - Update: sa>>=1, sb>>=1, shift d into the MSB of the result register (right shift), borrow FF<=bo, counter++.
    - When counter reaches WIDTH-1 at the edge, the last bit is processed, the result register is final, and the state goes to DONE.
  - DONE: done=1 for exactly one cycle; borrow output = borrow FF. Next edge -> IDLE.
- Latency: start accepted at edge k; RUN occupies edges k+1..k+WIDTH; done high in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after acceptance.
- Throughput: one result per WIDTH+2 cycles when start is held high.
- start while busy (RUN or DONE) is ignored; a/b changes while busy have no effect.
- diff/borrow outputs update only at the RUN->DONE edge.
  - Between operations they hold the last result.
  - The internal partial result is not visible on diff during RUN; use a separate output register loaded at the RUN->DONE edge.
- No overflow signalling beyond borrow; wrap-around is modulo 2^WIDTH.

Decomposition:
- Shared package/header sd112_pkg: state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 illegal, decodes to IDLE), default WIDTH.
- Sub-module half_subtractor (ports x, y, d, bo; d=x^y, bo=~x&y).
  - Instantiate twice plus an OR to form the full-subtractor slice.
  - It gets its own small exhaustive bench, mirroring the half-adder bench style.

Test Plan (WIDTH=8):
- Nominal: a=200, b=55, start one cycle -> done pulses exactly 9 cycles after the start edge; diff=145 (0x91), borrow=0, busy high 9 cycles.
- Borrow: a=5, b=10 -> diff=251 (0xFB), borrow=1.
- Corners:
  - 0-0 -> diff=0, borrow=0.
  - 0xFF-0xFF -> diff=0, borrow=0.
  - 0x00-0x01 -> diff=0xFF, borrow=1.
- Back-to-back with start held high:
  - 0x10-0x01 then 0x01-0x10 -> results 0x0F/b0 then 0xF1/b1.
  - Second done arrives 10 cycles after the first.
  - a/b changed during RUN are ignored.
- Reset mid-op: rst asserted asynchronously (between edges) at RUN bit 4 -> busy=0, diff=0, borrow=0 immediately, no done. A new op 100-1 after release -> diff=99, borrow=0.
- Self-check: randomized a/b (>=200 ops) compared against (a-b) mod 256 and (a<b) at every done; $monitor table prints a, b, diff, borrow.

Source files
------------

// File: rtl/sd112_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the default operand width.
package sd112_pkg;

  localparam int DEFAULT_WIDTH = 8;

  // 2'd3 is never entered. If it is ever seen, it decodes back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_half_subtractor.sv
// Half-subtractor: the difference bit and the borrow-out of x - y.
// Two of these plus an OR gate form one full-subtractor bit-slice.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor (diff = a - b), LSB first, one bit per clock,
// behind a start/busy/done handshake.
module serial_subtractor
  import sd112_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] sa, sb, acc;
  logic [CNT_W-1:0] cnt;
  logic             borrow_ff;

  // Full-subtractor slice: x - y - bi.
  logic d_xy, bo_xy, d_bit, bo_in, bo_bit;

  half_subtractor u_hs_xy (
    .x  (sa[0]),
    .y  (sb[0]),
    .d  (d_xy),
    .bo (bo_xy)
  );

  half_subtractor u_hs_bi (
    .x  (d_xy),
    .y  (borrow_ff),
    .d  (d_bit),
    .bo (bo_in)
  );

  assign bo_bit = bo_xy | bo_in;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = start ? RUN : IDLE;
      RUN:     next_state = (cnt == LAST_BIT) ? DONE : RUN;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa        <= '0;
      sb        <= '0;
      acc       <= '0;
      cnt       <= '0;
      borrow_ff <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sa        <= a;
          sb        <= b;
          borrow_ff <= 1'b0;
          cnt       <= '0;
        end
        RUN: begin
          sa        <= sa >> 1;
          sb        <= sb >> 1;
          acc       <= {d_bit, acc[WIDTH-1:1]};
          borrow_ff <= bo_bit;
          cnt       <= cnt + 1'b1;
          // The result is published only on the last bit. The partial sum never reaches diff.
          if (cnt == LAST_BIT) begin
            diff   <= {d_bit, acc[WIDTH-1:1]};
            borrow <= bo_bit;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8) plus an exhaustive check of
// the half_subtractor cell.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic             borrow;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             busy, done, borrow;
  logic [WIDTH-1:0] diff;

  logic hx, hy, hd, hbo;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  logic prev_done = 1'b0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  half_subtractor u_hs (
    .x  (hx),
    .y  (hy),
    .d  (hd),
    .bo (hbo)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (done) begin
      check("done_pulse_width", {31'd0, prev_done}, 0);
      if (sb_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("diff", {24'd0, diff}, {24'd0, e.diff});
        check("borrow", {31'd0, borrow}, {31'd0, e.borrow});
      end
    end
    prev_done <= done;
  end

  task automatic push_exp(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb);
    exp_t e;
    logic [WIDTH-1:0] d;
    d = ta - tb;
    e.diff   = d;
    e.borrow = (ta < tb);
    sb_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb, input bit timing);
    int  n, busy_n;
    bit  seen;
    wait_idle();
    a = ta;
    b = tb;
    start = 1'b1;
    push_exp(ta, tb);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; busy_n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
      if (done) seen = 1;
    end
    check("done_seen", {31'd0, seen}, 1);
    if (timing) begin
      check("latency", n, WIDTH + 1);
      check("busy_cycles", busy_n, WIDTH + 1);
      @(negedge clk);
      check("busy_after_done", {31'd0, busy}, 0);
    end
  endtask

  initial begin
    logic [3:0] d_tab, bo_tab;
    int  n, m;
    bit  seen;

    $monitor("a=%0d b=%0d done=%0b diff=%0d borrow=%0b", a, b, done, diff, borrow);

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    hx = 1'b0; hy = 1'b0;

    // Exhaustive cell check, indexed by {x,y}.
    d_tab  = 4'b0110;
    bo_tab = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      {hx, hy} = 2'(i);
      #1;
      check("hs_d", {31'd0, hd}, {31'd0, d_tab[i]});
      check("hs_bo", {31'd0, hbo}, {31'd0, bo_tab[i]});
    end

    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_diff", {24'd0, diff}, 0);
    check("rst_borrow", {31'd0, borrow}, 0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors.
    do_op(8'd200, 8'd55, 1);
    do_op(8'd5, 8'd10, 1);
    do_op(8'h00, 8'h00, 1);
    do_op(8'hFF, 8'hFF, 1);
    do_op(8'h00, 8'h01, 1);

    // Back-to-back with start held high. Operand changes while busy must be ignored.
    wait_idle();
    a = 8'h10; b = 8'h01; start = 1'b1;
    push_exp(8'h10, 8'h01);
    push_exp(8'h01, 8'h10);
    @(posedge clk);
    #1 a = 8'h01; b = 8'h10;
    n = 0; seen = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (done) seen = 1;
    end
    check("b2b_first_done", {31'd0, seen}, 1);
    m = 0; seen = 0;
    while (!seen && m < 40) begin
      @(negedge clk);
      m++;
      if (m == 2) begin
        a = 8'hAA;
        b = 8'h55;
      end
      if (done) seen = 1;
    end
    start = 1'b0;
    check("b2b_spacing", m, WIDTH + 2);

    // Asynchronous reset mid-operation, at RUN bit 4.
    wait_idle();
    a = 8'h5A; b = 8'h33; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 0);
    check("midrst_done", {31'd0, done}, 0);
    check("midrst_diff", {24'd0, diff}, 0);
    check("midrst_borrow", {31'd0, borrow}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    do_op(8'd100, 8'd1, 1);

    // Randomized operands.
    for (int i = 0; i < 200; i++) begin
      do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 0);
    $monitoroff;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
